// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU memory-side responder.
package mem_pkg;

  localparam int unsigned DefaultAddrWidth = 8;
  localparam int unsigned DefaultDataWidth = 8;
  localparam int unsigned MaxWaitStates    = 7;
  localparam int unsigned CntWidth         = $clog2(MaxWaitStates + 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } mem_state_t;

  // A request is legal only when exactly one direction qualifier is set.
  function automatic logic is_legal_req(input logic we, input logic oe);
    return we ^ oe;
  endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// Single-beat request/response bus between the CPU (or loader) and the memory responder.
interface cpu_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = mem_pkg::DefaultAddrWidth,
  parameter int unsigned DATA_WIDTH = mem_pkg::DefaultDataWidth
) ();

  logic                  cs;
  logic                  we;
  logic                  oe;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  busy;
  logic                  err;

  modport master (
    output cs, we, oe, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  cs, we, oe, addr, wdata,
    output rdata, ready, busy, err
  );

endinterface

// File: rtl/mem_array.sv
// Word-addressed storage with synchronous write and registered synchronous read.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Only the read register is reset, so rdata starts at zero and holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: accepts one request, waits WAIT_STATES cycles, commits, strobes ready.
module cpu_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefaultAddrWidth,
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic                clk,
  input logic                rst_n,
  cpu_mem_responder_if.slave bus
);

  localparam logic [CntWidth-1:0] WaitLoad = CntWidth'(WAIT_STATES);

  mem_state_t            state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  err_q;
  logic                  commit;

  // The access happens on the edge that moves WAIT into RESP.
  assign commit = (state_q == StWait) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cs) begin
            if (is_legal_req(bus.we, bus.oe)) begin
              addr_q  <= bus.addr;
              wdata_q <= bus.wdata;
              write_q <= bus.we;
              cnt_q   <= WaitLoad;
              busy_q  <= 1'b1;
              state_q <= StWait;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            ready_q <= 1'b1;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit && write_q),
    .re    (commit && !write_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (bus.rdata)
  );

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule
